// File: rtl/fifo_frame_pkg.sv
// Shared types and constants for the audio FIFO frame reader.
// Holds the reader FSM state type, default sizes and a clog2 helper.
package fifo_frame_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int SAMPLE_W      = 16;
  localparam int FRAME_LEN_DEF = 512;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_frame_reader_stream_skid2.sv
// stream_skid2: 2-entry valid/ready holding buffer with registered outputs.
// The caller guarantees it never pushes into a full buffer without a pop.
module stream_skid2 #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_m_ready,
  output logic             o_m_valid,
  output logic [WIDTH-1:0] o_m_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop     = (r_count != 2'd0) && i_m_ready;
  assign o_m_valid = (r_count != 2'd0);
  assign o_m_data  = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        r_mem[gi] <= '0;
      end else if (i_push && (r_wr_ptr == 1'(gi))) begin
        r_mem[gi] <= i_push_data;
      end
    end
  end

  // Head slot only moves on a pop, so the output holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      r_wr_ptr <= r_wr_ptr ^ i_push;
      r_rd_ptr <= r_rd_ptr ^ w_pop;
      r_count  <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains one FRAME_LEN-sample frame from the audio FIFO into a valid/ready stream.
// Optional statistics outputs are enabled with FIFO_FRAME_READER_STATS_EN.
module fifo_frame_reader
  import fifo_frame_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W,
  parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  fifo_almost_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  underrun
`ifdef FIFO_FRAME_READER_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam int             IDX_W     = clog2_f(FRAME_LEN);
  localparam logic [IDX_W:0] LAST_IDX  = (IDX_W+1)'(FRAME_LEN - 1);
  localparam logic [IDX_W:0] FRAME_CNT = (IDX_W+1)'(FRAME_LEN);

  state_e              r_state;
  state_e              w_state_next;
  logic [IDX_W:0]      r_issued;
  logic [IDX_W:0]      r_push_idx;
  logic                r_inflight;
  logic                r_underrun;
  logic [1:0]          w_held;
  logic [2:0]          w_occ_after;
  logic                w_pop;
  logic                w_issue;
  logic                w_push_last;
  logic                w_underrun_cond;
  logic [DATA_WIDTH:0] w_skid_out;

  assign w_pop       = m_valid && m_ready;
  // Occupancy counts reads still in flight so the buffer can never overflow.
  assign w_occ_after = 3'(w_held) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue     = !rst && (r_state == BURST) && !fifo_rd_empty &&
                       (r_issued < FRAME_CNT) && (w_occ_after < 3'd2);
  assign w_underrun_cond = (r_state == BURST) && (r_issued < FRAME_CNT) && fifo_rd_empty;
  assign w_push_last = (r_push_idx == LAST_IDX);

  assign fifo_rd_en = w_issue;
  assign busy       = (r_state != ARM);
  assign underrun   = r_underrun;
  assign m_data     = w_skid_out[DATA_WIDTH-1:0];
  assign m_last     = m_valid && w_skid_out[DATA_WIDTH];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARM:     if (!fifo_almost_empty) w_state_next = BURST;
      BURST:   if (w_issue && (r_issued == LAST_IDX)) w_state_next = FLUSH;
      FLUSH:   if ((w_held == 2'd0) && !r_inflight) w_state_next = ARM;
      default: w_state_next = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARM;
      r_issued   <= '0;
      r_push_idx <= '0;
      r_inflight <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      if (r_state == ARM) begin
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + (IDX_W+1)'(1);
      end
      if (r_inflight) begin
        r_push_idx <= w_push_last ? '0 : r_push_idx + (IDX_W+1)'(1);
      end
      if (w_underrun_cond) r_underrun <= 1'b1;
    end
  end

  stream_skid2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data ({w_push_last, fifo_rd_data}),
    .i_m_ready   (m_ready),
    .o_m_valid   (m_valid),
    .o_m_data    (w_skid_out),
    .o_count     (w_held)
  );

`ifdef FIFO_FRAME_READER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_underrun_cnt;
  logic        r_uflow_prev;

  // One count per underrun episode: only the first empty cycle of a run counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt    <= 16'd0;
      r_underrun_cnt <= 16'd0;
      r_uflow_prev   <= 1'b0;
    end else begin
      r_uflow_prev <= w_underrun_cond;
      if (w_pop && m_last) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_underrun_cond && !r_uflow_prev && (r_underrun_cnt != 16'hFFFF)) begin
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt    = r_frame_cnt;
  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule
